// File: rtl/demux1x2_stream_if.sv
// Valid/ready bundle for one input and two output channels of the 1-to-2 demux.
interface demux1x2_stream_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;

  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;

  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;

  modport slave (
    input  in_valid, in_sel, in_data,
    output in_ready,
    output out0_valid, out0_data,
    input  out0_ready,
    output out1_valid, out1_data,
    input  out1_ready
  );

  modport master (
    output in_valid, in_sel, in_data,
    input  in_ready,
    input  out0_valid, out0_data,
    output out0_ready,
    input  out1_valid, out1_data,
    output out1_ready
  );
endinterface

// File: rtl/demux1x2_stream.sv
// 1-to-2 stream demux with a 2-entry FIFO per output; 1-cycle latency, in_ready drops only when the selected FIFO is full.
// Optional per-channel accepted-beat counters are compiled in with DEMUX_STATS_EN.
module demux1x2_stream #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  demux1x2_stream_if.slave    bus
`ifdef DEMUX_STATS_EN
  ,
  input  logic                stats_clr,
  output logic [15:0]         cnt0,
  output logic [15:0]         cnt1
`endif
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  occ_t             r_occ     [2];
  occ_t             w_occ_nxt [2];
  logic [WIDTH-1:0] r_mem     [2][2];
  logic [1:0]       r_wptr;
  logic [1:0]       r_rptr;

  logic             w_in_rdy;
  logic             w_acc;
  logic [1:0]       w_push;
  logic [1:0]       w_pop;
  logic [1:0]       w_out_vld;
  logic [1:0]       w_out_rdy;

  // in_ready looks only at the selected channel's registered occupancy, never at the consumer's ready.
  always_comb begin
    w_out_rdy = {bus.out1_ready, bus.out0_ready};
    w_in_rdy  = (r_occ[bus.in_sel] != OCC_FULL);
    w_acc     = bus.in_valid & w_in_rdy;
    w_push[0] = w_acc & ~bus.in_sel;
    w_push[1] = w_acc &  bus.in_sel;
    for (int k = 0; k < 2; k++) begin
      w_out_vld[k] = (r_occ[k] != OCC_EMPTY);
      w_pop[k]     = w_out_vld[k] & w_out_rdy[k];
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      w_occ_nxt[k] = r_occ[k];
      case ({w_push[k], w_pop[k]})
        2'b10: w_occ_nxt[k] = (r_occ[k] == OCC_EMPTY) ? OCC_ONE : OCC_FULL;
        2'b01: w_occ_nxt[k] = (r_occ[k] == OCC_FULL) ? OCC_ONE : OCC_EMPTY;
        default: w_occ_nxt[k] = r_occ[k];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        r_occ[k]    <= OCC_EMPTY;
        r_mem[k][0] <= '0;
        r_mem[k][1] <= '0;
      end
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        r_occ[k] <= w_occ_nxt[k];
        if (w_push[k]) begin
          r_mem[k][r_wptr[k]] <= bus.in_data;
          r_wptr[k]           <= ~r_wptr[k];
        end
        if (w_pop[k]) begin
          r_rptr[k] <= ~r_rptr[k];
        end
      end
    end
  end

  assign bus.in_ready   = w_in_rdy;
  assign bus.out0_valid = w_out_vld[0];
  assign bus.out1_valid = w_out_vld[1];
  assign bus.out0_data  = r_mem[0][r_rptr[0]];
  assign bus.out1_data  = r_mem[1][r_rptr[1]];

`ifdef DEMUX_STATS_EN
  logic [15:0] r_cnt0;
  logic [15:0] r_cnt1;

  // Clear wins over a push landing in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || stats_clr) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_push[0] && (r_cnt0 != 16'hFFFF)) r_cnt0 <= r_cnt0 + 16'd1;
      if (w_push[1] && (r_cnt1 != 16'hFFFF)) r_cnt1 <= r_cnt1 + 16'd1;
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
`endif

endmodule

// File: doc/demux1x2_stream.md
# demux1x2_stream

Registered 1-to-2 stream demultiplexer: the routing counterpart of the `mux2x1` select path. It accepts beats on one valid/ready input and steers each beat, by a per-beat select bit, into one of two output channels. Each output has a 2-entry FIFO, so backpressure on one output does not stall beats routed to the other until that output's FIFO is full. It sits between a single producer and two independent consumers in the datapath.

## Interface
- `WIDTH`, 8, data width in bits (≥1).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: input beat present.
- `in_ready` out 1: input beat accepted this cycle when `in_valid & in_ready`.
- `in_sel` in 1: destination of the beat; 0 routes to out0, 1 routes to out1.
- `in_data` in WIDTH: input payload.
- `out0_valid` out 1 / `out0_ready` in 1 / `out0_data` out WIDTH: output channel 0.
- `out1_valid` out 1 / `out1_ready` in 1 / `out1_data` out WIDTH: output channel 1.
- `stats_clr` in 1: synchronous clear of the beat counters (only with `DEMUX_STATS_EN`).
- `cnt0` out 16 / `cnt1` out 16: accepted-beat counters per output (only with `DEMUX_STATS_EN`).

## Operation
- Each output channel k has a 2-entry FIFO with an occupancy state EMPTY(0), ONE(1) or FULL(2), a write pointer and a read pointer.
- `in_ready = (occ[in_sel] != FULL)`. This is combinational from `in_sel` and registered state only. It does not depend on `outk_ready`.
- Push to channel k: `in_valid & in_ready & (in_sel == k)`. The FIFO write pointer toggles.
- `outk_valid = (occ[k] != EMPTY)`. `outk_data` = the FIFO head entry, driven from a register.
- Pop from channel k: `outk_valid & outk_ready`. The read pointer toggles.
- Occupancy transitions:
  - push only: +1.
  - pop only: −1.
  - push and pop in the same cycle: unchanged. This is legal only in ONE, because FULL blocks the push and EMPTY has no pop.
- The unselected channel is never written. Its occupancy changes only through its own pop.
- Order is preserved within each channel. No ordering is implied between channels.
- While `outk_valid & !outk_ready`, `outk_data` and `outk_valid` hold stable.
- Reset, including reset asserted mid-transfer, discards all FIFO contents. Resulting values:
  - `occ` = EMPTY, pointers = 0.
  - `out0_valid = out1_valid = 0`, and `in_ready` = 1.
  - `out0_data = out1_data = 0` (storage cleared).
  - `cnt0 = cnt1 = 0`.
- `in_data` and `in_sel` are don't-care when `in_valid` = 0.

## Timing
- Latency: a beat accepted at edge N appears on `outk_valid/outk_data` after edge N, i.e. one cycle.
- Throughput: one beat per cycle sustained to either channel while its consumer holds ready = 1, since occupancy stays at ONE.
- When a channel is FULL and its consumer pops at edge N, `in_ready` for that `in_sel` rises after edge N. There is no same-cycle pass-through.
- Handshakes complete on the rising edge where valid & ready are both sampled high. Producers must not drop `in_valid` or change `in_data` / `in_sel` before acceptance.

## Configuration
- `DEMUX_STATS_EN` defined:
  - Ports `stats_clr`, `cnt0` and `cnt1` exist.
  - `cntk` increments by 1 on each push to channel k and saturates at 16'hFFFF.
  - `stats_clr` = 1 sets both counters to 0 at the next edge. A push in the same cycle is not counted; clear has priority.
- `DEMUX_STATS_EN` undefined:
  - The three ports and the counter logic are absent.
  - Routing behaviour is identical.

## Test plan
- Reset: drive `rst_n` = 0 for 2 cycles with `in_valid` = 1 → `out0_valid = out1_valid = 0` and `in_ready` = 1 while in reset; no beat is accepted.
- Alternating route: `out0_ready = out1_ready = 1`, send 8'h11 (sel 0), 8'h22 (sel 1), 8'h33 (sel 0) on consecutive cycles → out0 emits 11 then 33, and out1 emits 22. Each beat appears one cycle after acceptance.
- Backpressure isolation: `out0_ready` = 0, send 8'hA0, 8'hA1 to sel 0 → `in_ready` drops with sel = 0. A beat 8'hB0 to sel 1 is still accepted and emitted on out1. Raising `out0_ready` later drains A0 then A1.
- Full boundary: channel 1 FULL holding 8'hC0, 8'hC1, with `in_valid` = 1, sel = 1, data 8'hC2 → no accept. A pop of C0 at edge N, then C2 is accepted at edge N+1, and out1 order is C0, C1, C2.
- Mid-transfer reset: channel 0 ONE holding 8'h55 with `out0_ready` = 0, then assert `rst_n` = 0 for one cycle → `out0_valid` = 0 afterwards and 8'h55 is never emitted.
- Stats (`DEMUX_STATS_EN`):
  - Push 3 beats to sel 0 and 1 beat to sel 1 → `cnt0` = 3, `cnt1` = 1.
  - Pulse `stats_clr` together with a push to sel 0 → both counters are 0.
  - Preload `cnt1` near 16'hFFFF via 70000 pushes → `cnt1` = 16'hFFFF.
